// File: rtl/regfile_responder.sv
// regfile_responder: 2^ADDR_BITS x WIDTH architectural register file.
// It has two combinational read ports and one clocked write port.
// Register 0 is hard-wired to zero.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN. When it is defined, an
// in-flight write is forwarded combinationally to any read port whose
// address matches the write address.

// One storage entry. The write-enable arrives already decoded and gated by
// RegWrite, so an X on the address or data cannot reach the flop while the
// entry is idle.
module regfile_entry #(
  parameter int WIDTH = 32
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_d, data_q;

  // Hold the stored value unless this entry is the write target.
  always_comb begin
    data_d = data_q;
    if (we) data_d = wd;
  end

  // Async clear has priority, so an edge that arrives while reset is low
  // cannot load data.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) data_q <= '0;
    else         data_q <= data_d;
  end

  assign q = data_q;
endmodule

module regfile_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite
);
  localparam int N = 1 << ADDR_BITS;

  logic [N-1:0][WIDTH-1:0] regs;
  logic [N-1:1]            we;

  // Entry 0 has no storage and always reads zero.
  assign regs[0] = '0;

  // One-hot write decode. RegWrite=0 forces every enable low, even if
  // WriteRegister is X.
  always_comb begin
    we = '0;
    for (int i = 1; i < N; i++)
      we[i] = RegWrite && (WriteRegister == ADDR_BITS'(i));
  end

  for (genvar i = 1; i < N; i++) begin : g_ent
    regfile_entry #(.WIDTH(WIDTH)) u_ent (
      .gclk  (Clk),
      .grst_n(Reset_n),
      .we    (we[i]),
      .wd    (WriteData),
      .q     (regs[i])
    );
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = RegWrite && Reset_n && (WriteRegister != '0);

  // Each read port is an independent mux. A matching in-flight write is
  // forwarded to the port. Address 0 never matches, because byp_ok excludes it.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadData2 = regs[ReadRegister2];
    if (byp_ok && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
    if (byp_ok && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
  end
`else
  // Each read port is an independent mux that reads stored contents only.
  // There is no path from WriteData to ReadData.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadData2 = regs[ReadRegister2];
  end
`endif
endmodule
